// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and the conditional-negate helper for muldiv_unit
package muldiv_pkg;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam int MAXW = 128;
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIXUP} state_t;
  function automatic logic [MAXW-1:0] neg_if(input logic [MAXW-1:0] value, input logic cond);
    return cond ? -value : value;
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider owning the HI/LO pair
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [W2-1:0] acc, acc_nx, prod_fix;
  logic [WIDTH-1:0] ra, rb, a_mag, b_mag, quo_fix, rem_fix;
  logic [WIDTH:0] sum, trial;
  logic is_div, sa, sb, bz, arith;
  // one datapath step: multiply adds into the upper half and shifts right, divide shifts left and trial-subtracts
  always_comb begin
    arith    = op <= OP_DIVU;
    a_mag    = WIDTH'(neg_if(MAXW'(ra), sa));
    b_mag    = WIDTH'(neg_if(MAXW'(rb), sb));
    sum      = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (rb[0] ? ra : {WIDTH{1'b0}})};
    trial    = acc[W2-1:WIDTH-1] - {1'b0, rb};
    acc_nx   = is_div ? (trial[WIDTH] ? {acc[W2-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                      : {sum, acc[WIDTH-1:1]};
    prod_fix = W2'(neg_if(MAXW'(acc), sa ^ sb));
    quo_fix  = bz ? {WIDTH{1'b1}} : WIDTH'(neg_if(MAXW'(acc[WIDTH-1:0]), sa ^ sb));
    rem_fix  = WIDTH'(neg_if(MAXW'(acc[W2-1:WIDTH]), sa));
  end
  // control FSM plus operand, accumulator and HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      ra     <= '0;
      rb     <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      bz     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && arith) begin
              ra     <= a;
              rb     <= b;
              is_div <= op[1];
              sa     <= ~op[0] & a[WIDTH-1];
              sb     <= ~op[0] & b[WIDTH-1];
              bz     <= b == '0;
              busy   <= 1'b1;
              state  <= S_PREP;
            end else if (start && op == OP_MTHI) begin
              hi <= a;
            end else if (start && op == OP_MTLO) begin
              lo <= a;
            end
          end
          S_PREP: begin
            ra    <= a_mag;
            rb    <= b_mag;
            acc   <= is_div ? {{WIDTH{1'b0}}, a_mag} : '0;
            cnt   <= '0;
            state <= S_RUN;
          end
          S_RUN: begin
            acc   <= acc_nx;
            rb    <= is_div ? rb : rb >> 1;
            cnt   <= cnt + 1'b1;
            state <= cnt == LAST ? S_FIXUP : S_RUN;
          end
          default: begin
            hi    <= is_div ? rem_fix : prod_fix[W2-1:WIDTH];
            lo    <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus handshake, flush and reset sequences for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int n_vec = 0, n_bad = 0;
  vec_t vecs[15];
  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask
  task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask
  initial begin
    int lat, sd;
    logic [31:0] h0, l0;
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[7]  = '{OP_MULTU, 32'h12345678, 32'h10,       32'd1,        32'h23456780};
    vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
    vecs[12] = '{OP_MULTU, 32'hFFFFFFFD, 32'd7,        32'd6,        32'hFFFFFFEB};
    vecs[13] = '{OP_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2};
    vecs[14] = '{OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    go(OP_MTLO, 32'h1234, 32'd0);
    chk("mtlo lo", lo, 32'h1234);
    chk("mtlo busy", {31'd0, busy}, 32'd0);
    go(OP_MTHI, 32'hABCD, 32'd0);
    chk("mthi hi", hi, 32'hABCD);
    chk("mthi lo kept", lo, 32'h1234);
    chk("mthi done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      go(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d busy after accept", i), {31'd0, busy}, 32'd1);
      wait_done(lat);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd34);
      chk($sformatf("v%0d hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d busy at done", i), {31'd0, busy}, 32'd0);
    end
    go(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = OP_MULTU; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    chk("ignored start latency", 32'(lat + 5), 32'd34);
    chk("ignored start hi", hi, 32'd2);
    chk("ignored start lo", lo, 32'd14);
    @(posedge clk);
    #1 chk("done one cycle", {31'd0, done}, 32'd0);
    go(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    sd = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) sd = 1;
    end
    chk("flush no done", 32'(sd), 32'd0);
    chk("flush hi kept", hi, 32'd2);
    chk("flush lo kept", lo, 32'd14);
    go(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (32) @(posedge clk);
    @(negedge clk);
    chk("pre-fixup busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("fixup flush done", {31'd0, done}, 32'd0);
    chk("fixup flush busy", {31'd0, busy}, 32'd0);
    chk("fixup flush hi", hi, 32'd2);
    chk("fixup flush lo", lo, 32'd14);
    @(negedge clk);
    op = OP_MTLO; a = 32'hDEAD; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    flush = 1'b0;
    chk("flush+mtlo lo", lo, 32'd14);
    chk("flush+mtlo busy", {31'd0, busy}, 32'd0);
    go(OP_MULT, 32'd9, 32'd9);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst hi", hi, 32'd0);
    chk("async rst lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    go(OP_DIVU, 32'd50, 32'd8);
    wait_done(lat);
    chk("post rst latency", 32'(lat), 32'd34);
    chk("post rst lo", lo, 32'd6);
    chk("post rst hi", hi, 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
